endpoint_tx_loader: RTL and testbench

Bus master that sits directly upstream of the chiplet endpoint's peripheral bus port. It accepts one packet command plus a stream of 32-bit words from a host-side producer. It then writes the words into the endpoint TX cache window, programs the packet's start-address slot, and triggers the send. This removes per-word software bus traffic for packet transmit.

---
 rtl/endpoint_tx_loader.sv | 204 ++++++++++++++++++++
 tb/tb_endpoint_tx_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/endpoint_tx_loader.sv
// Bus master that streams payload words into the endpoint TX cache, then programs and triggers the send.
// Optional word readback/verify after each cache write: define ENDPOINT_TX_LOADER_READBACK_EN.
module endpoint_tx_loader #(
    parameter int          NUM_MSGS        = 4,
    parameter int          CACHE_NUM_WORDS = 128,
    parameter logic [31:0] TX_CACHE_BASE   = 32'h2000,
    parameter logic [31:0] TX_SEND_ADDR    = 32'h1004,
    localparam int         IDW             = $clog2(NUM_MSGS),
    localparam int         OW              = $clog2(CACHE_NUM_WORDS),
    localparam int         LW              = OW + 1
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [IDW-1:0] cmd_msg_id,
    input  logic [OW-1:0]  cmd_word_offset,
    input  logic [LW-1:0]  cmd_len,
    input  logic           data_valid,
    output logic           data_ready,
    input  logic [31:0]    data_word,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [31:0]    bus_addr,
    output logic           bus_wen,
    output logic           bus_ren,
    output logic [31:0]    bus_wdata,
    output logic [3:0]     bus_strobe,
    input  logic [31:0]    bus_rdata,
    input  logic           bus_error,
    input  logic           bus_request_stall
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PTR   = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    localparam logic [LW-1:0] ONE   = LW'(1);
    localparam logic [LW:0]   DEPTH = (LW+1)'(CACHE_NUM_WORDS);

    logic [2:0]     state;
    logic [IDW-1:0] msg_id_q;
    logic [OW-1:0]  off_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  idx_q;
    logic [31:0]    wr_addr_q;
    logic [31:0]    beat_data;
    logic           beat_valid;
    logic           done_q;
    logic           err_q;
    logic           rd_phase;

    logic [LW:0]    end_w;
    logic           reject;
    logic           xfer;
    logic           beat_fin;
    logic           abort;
    logic           last_beat;

    // One extra bit so offset+len can never wrap past the window check
    assign end_w     = (LW+1)'(cmd_word_offset) + (LW+1)'(cmd_len);
    assign reject    = (cmd_len == '0) || (end_w > DEPTH);
    assign xfer      = (bus_wen | bus_ren) & ~bus_request_stall;
    assign last_beat = (idx_q + ONE) == len_q;

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign data_ready = (state == S_LOAD) && !beat_valid;
    assign done       = done_q;
    assign err        = err_q;
    assign bus_strobe = {4{bus_wen}};

`ifdef ENDPOINT_TX_LOADER_READBACK_EN
    assign bus_ren = (state == S_LOAD) && beat_valid && rd_phase;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus_rdata;
    assign rd_phase     = 1'b0;
    assign bus_ren      = 1'b0;
`endif

    always_comb begin
        beat_fin = 1'b0;
        abort    = 1'b0;
        if (xfer) begin
            if (bus_error) begin
                abort = 1'b1;
            end else if (state == S_LOAD) begin
`ifdef ENDPOINT_TX_LOADER_READBACK_EN
                if (rd_phase) begin
                    if (bus_rdata != beat_data) abort = 1'b1;
                    else beat_fin = 1'b1;
                end
`else
                beat_fin = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        bus_wen   = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            S_LOAD: begin
                if (beat_valid) begin
                    bus_addr  = wr_addr_q;
                    bus_wdata = beat_data;
                    bus_wen   = !rd_phase;
                end
            end
            S_PTR: begin
                bus_wen   = 1'b1;
                bus_addr  = 32'(msg_id_q) << 2;
                bus_wdata = 32'(off_q) << 2;
            end
            S_SEND: begin
                bus_wen   = 1'b1;
                bus_addr  = TX_SEND_ADDR;
                bus_wdata = 32'(msg_id_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            msg_id_q   <= '0;
            off_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            wr_addr_q  <= '0;
            beat_data  <= '0;
            beat_valid <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ENDPOINT_TX_LOADER_READBACK_EN
            rd_phase   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        msg_id_q <= cmd_msg_id;
                        off_q    <= cmd_word_offset;
                        len_q    <= cmd_len;
                        idx_q    <= '0;
                        if (reject) err_q <= 1'b1;
                        else state <= S_SETUP;
                    end
                end
                // Precompute the first cache byte address so LOAD only increments
                S_SETUP: begin
                    wr_addr_q <= TX_CACHE_BASE + (32'(off_q) << 2);
                    state     <= S_LOAD;
                end
                S_LOAD: begin
                    if (data_ready && data_valid) begin
                        beat_valid <= 1'b1;
                        beat_data  <= data_word;
                    end
`ifdef ENDPOINT_TX_LOADER_READBACK_EN
                    if (xfer && !rd_phase && !bus_error) rd_phase <= 1'b1;
`endif
                    if (beat_fin) begin
                        beat_valid <= 1'b0;
`ifdef ENDPOINT_TX_LOADER_READBACK_EN
                        rd_phase   <= 1'b0;
`endif
                        idx_q      <= idx_q + ONE;
                        wr_addr_q  <= wr_addr_q + 32'd4;
                        if (last_beat) state <= S_PTR;
                    end
                end
                S_PTR: begin
                    if (xfer && !bus_error) state <= S_SEND;
                end
                S_SEND: begin
                    if (xfer && !bus_error) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (abort) begin
                err_q      <= 1'b1;
                state      <= S_IDLE;
                beat_valid <= 1'b0;
`ifdef ENDPOINT_TX_LOADER_READBACK_EN
                rd_phase   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_endpoint_tx_loader.sv
// Randomized bench for endpoint_tx_loader against a transaction-level reference model.
// Expected bus traffic is built from command fields; observed completions are logged and compared.
module tb_endpoint_tx_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } acc_t;

`ifdef ENDPOINT_TX_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_msg_id;
    logic [6:0]  cmd_word_offset;
    logic [7:0]  cmd_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_word;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strobe;
    logic [31:0] bus_rdata;
    logic        bus_error;
    logic        bus_request_stall;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    endpoint_tx_loader dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_msg_id(cmd_msg_id), .cmd_word_offset(cmd_word_offset),
        .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready),
        .data_word(data_word),
        .busy(busy), .done(done), .err(err),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_rdata(bus_rdata), .bus_error(bus_error),
        .bus_request_stall(bus_request_stall)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_wen"}, 32'(bus_wen), 32'd0);
        check({tag, "_ren"}, 32'(bus_ren), 32'd0);
        check({tag, "_addr"}, bus_addr, 32'd0);
        check({tag, "_wdata"}, bus_wdata, 32'd0);
        check({tag, "_strobe"}, 32'(bus_strobe), 32'd0);
    endtask

    // smode: 0 no stall, 1 four-cycle stall on access #1, 2 random stall
    task automatic run_cmd(input int id, input int off, input int len,
                           input int smode, input int err_at, input int rb_bad,
                           input int rst_at, input int lat_exp, input bit gaps);
        acc_t        exp_q[$];
        acc_t        log_q[$];
        logic [31:0] w[$];
        logic [31:0] rd;
        logic [31:0] paddr, pwdata;
        logic        pwen, pst, active;
        bit          accepted, rej, exp_err;
        int          wi, nacc, nrd, ndone, nerr, cyc, scnt, tail;
        int          acc_cyc, done_cyc, err_cyc, n;

        accepted = 0; pst = 0; paddr = '0; pwdata = '0; pwen = 0;
        wi = 0; nacc = 0; nrd = 0; ndone = 0; nerr = 0; cyc = 0;
        scnt = 0; tail = 0; acc_cyc = -1; done_cyc = -1; err_cyc = -1;
        for (int i = 0; i < len; i++) w.push_back($urandom);

        rej = (len == 0) || (off + len > 128);
        exp_err = rej;
        if (!rej) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back('{32'h2000 + 32'(4 * (off + i)), w[i], 1'b1});
                if (RB) begin
                    if (i == rb_bad)
                        exp_q.push_back('{32'h2000 + 32'(4 * (off + i)), ~w[i], 1'b0});
                    else
                        exp_q.push_back('{32'h2000 + 32'(4 * (off + i)), w[i], 1'b0});
                end
            end
            exp_q.push_back('{32'(4 * id), 32'(4 * off), 1'b1});
            exp_q.push_back('{32'h1004, 32'(id), 1'b1});
            if (RB && rb_bad >= 0 && rb_bad < len) begin
                exp_err = 1;
                while (exp_q.size() > 2 * rb_bad + 2) void'(exp_q.pop_back());
            end
            if (err_at >= 0 && err_at < exp_q.size()) begin
                exp_err = 1;
                while (exp_q.size() > err_at + 1) void'(exp_q.pop_back());
            end
        end

        cmd_msg_id      = 2'(id);
        cmd_word_offset = 7'(off);
        cmd_len         = 8'(len);

        while (cyc < 3000 && tail < 4) begin
            if (rst_at >= 0 && nacc == rst_at) begin
                n_rst = 1'b0;
                #1;
                check_idle_outputs("rst_mid");
                cmd_valid = 0; data_valid = 0;
                bus_request_stall = 0; bus_error = 0;
                @(posedge clk); #1;
                n_rst = 1'b1;
                check("rst_hit", 32'(nacc), 32'(rst_at));
                return;
            end
            cmd_valid  = !accepted;
            data_valid = accepted && wi < len && (!gaps || $urandom_range(0, 3) != 0);
            data_word  = (wi < len) ? w[wi] : 32'h0;
            active = bus_wen | bus_ren;
            case (smode)
                1: bus_request_stall = active && nacc == 1 && scnt < 4;
                2: bus_request_stall = active && $urandom_range(0, 3) == 0;
                default: bus_request_stall = 1'b0;
            endcase
            if (bus_request_stall && smode == 1) scnt++;
            bus_error = active && !bus_request_stall && nacc == err_at;
            rd = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
            bus_rdata = (bus_ren && nrd == rb_bad) ? ~rd : rd;
            #1;
            if (cmd_valid && cmd_ready) begin
                accepted = 1; acc_cyc = cyc;
            end
            if (data_valid && data_ready) wi++;
            if (active) begin
                if (pst) begin
                    check("hold_addr", bus_addr, paddr);
                    check("hold_wdata", bus_wdata, pwdata);
                    check("hold_wen", 32'(bus_wen), 32'(pwen));
                end
                check("dready_busy", 32'(data_ready), 32'd0);
                if (bus_wen) check("strobe", 32'(bus_strobe), 32'hF);
                if (!bus_request_stall) begin
                    if (bus_wen) begin
                        log_q.push_back('{bus_addr, bus_wdata, 1'b1});
                        mem[bus_addr] = bus_wdata;
                    end else begin
                        log_q.push_back('{bus_addr, bus_rdata, 1'b0});
                        nrd++;
                    end
                    nacc++;
                end
                pst = bus_request_stall; paddr = bus_addr;
                pwdata = bus_wdata; pwen = bus_wen;
            end else begin
                pst = 0;
            end
            if (done) begin ndone++; done_cyc = cyc; end
            if (err) begin
                nerr++; err_cyc = cyc;
                if (rej) check("rej_cmd_ready", 32'(cmd_ready), 32'd1);
            end
            if (accepted && (ndone + nerr) > 0) tail++;
            @(posedge clk); #1;
            cyc++;
        end
        cmd_valid = 0; data_valid = 0; bus_request_stall = 0; bus_error = 0;

        check("n_access", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("acc%0d_addr", i), log_q[i].addr, exp_q[i].addr);
            check($sformatf("acc%0d_data", i), log_q[i].data, exp_q[i].data);
            check($sformatf("acc%0d_wr", i), 32'(log_q[i].wr), 32'(exp_q[i].wr));
        end
        check("done_cnt", 32'(ndone), exp_err ? 32'd0 : 32'd1);
        check("err_cnt", 32'(nerr), exp_err ? 32'd1 : 32'd0);
        if (rej) check("rej_lat", 32'(err_cyc - acc_cyc), 32'd1);
        if (lat_exp > 0) check("done_lat", 32'(done_cyc - acc_cyc), 32'(lat_exp));
    endtask

    initial begin
        int lat, off, len, ea, ptr_idx;
        n_rst = 0; cmd_valid = 0; cmd_msg_id = 0; cmd_word_offset = 0;
        cmd_len = 0; data_valid = 0; data_word = 0; bus_rdata = 0;
        bus_error = 0; bus_request_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        n_rst = 1;
        @(posedge clk); #1;

        lat = RB ? 13 : 10;
        run_cmd(2, 8, 3, 0, -1, -1, -1, lat, 0);
        run_cmd(2, 8, 3, 1, -1, -1, -1, lat + 4, 0);
        run_cmd(0, 126, 3, 0, -1, -1, -1, 0, 0);
        run_cmd(1, 5, 0, 0, -1, -1, -1, 0, 0);
        run_cmd(3, 125, 3, 0, -1, -1, -1, 0, 0);
        ptr_idx = RB ? 4 : 2;
        run_cmd(1, 10, 2, 0, ptr_idx, -1, -1, 0, 0);
        run_cmd(1, 10, 2, 0, -1, -1, -1, 0, 0);
        run_cmd(0, 0, 4, 0, -1, -1, 1, 0, 0);
        run_cmd(0, 0, 4, 0, -1, -1, -1, 0, 0);
        if (RB) begin
            run_cmd(1, 4, 3, 0, -1, 1, -1, 0, 0);
            run_cmd(1, 4, 3, 0, -1, -1, -1, 0, 0);
        end

        for (int k = 0; k < 40; k++) begin
            off = $urandom_range(0, 127);
            if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 255);
            else len = $urandom_range(1, (128 - off) < 12 ? (128 - off) : 12);
            ea = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 2) : -1;
            run_cmd($urandom_range(0, 3), off, len, 2, ea, -1, -1, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
